// File: rtl/wr_burst_ctrl.sv
// Splits a user write job into AXI INCR bursts: one command strobe, then the burst's data beats.
// Optional WR_BURST_4K_SPLIT_EN: additionally clip each burst so it never crosses a 4KB boundary.
module wr_burst_ctrl #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 128,
   parameter int LEN_WIDTH      = 16,
   parameter int MAX_BURST      = 256
) (
   input  logic                      wr_clk,
   input  logic                      resetn,
   input  logic                      usr_wr_start,
   input  logic [AXI_ADDR_WIDTH-1:0] usr_wr_addr,
   input  logic [LEN_WIDTH-1:0]      usr_wr_len,
   input  logic [AXI_DATA_WIDTH-1:0] usr_data,
   input  logic                      usr_data_valid,
   output logic                      usr_data_ready,
   output logic                      usr_wr_busy,
   output logic                      usr_wr_done,
   input  logic                      wr_buf_afull,
   output logic                      wr_req_en,
   output logic [AXI_ADDR_WIDTH-1:0] wr_addr_in,
   output logic [7:0]                wr_burst_len,
   output logic [AXI_DATA_WIDTH-1:0] wr_data_in,
   output logic                      wr_data_valid,
   output logic                      wr_data_last
);
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
   state_t state, state_nxt;

   logic [AXI_ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]      rem;
   logic [8:0]                beats, cnt;
   logic [CW-1:0]             beats_calc;
   logic job_start, zero_start, cmd_fire, beat_acc, final_beat;

`ifdef WR_BURST_4K_SPLIT_EN
   logic [12:0] to4k;
   // addr is beat-aligned, so the shift is an exact division
   assign to4k = (13'd4096 - {1'b0, addr[11:0]}) >> BSH;
`endif

   always_comb begin
      beats_calc = (CW'(rem) > CW'(MAX_BURST)) ? CW'(MAX_BURST) : CW'(rem);
`ifdef WR_BURST_4K_SPLIT_EN
      if (CW'(to4k) < beats_calc) beats_calc = CW'(to4k);
`endif
   end

   always_ff @(posedge wr_clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      job_start  = 1'b0;
      zero_start = 1'b0;
      cmd_fire   = 1'b0;
      beat_acc   = 1'b0;
      final_beat = 1'b0;
      case (state)
         IDLE: if (usr_wr_start) begin
            if (usr_wr_len != '0) begin
               job_start = 1'b1;
               state_nxt = CMD;
            end else begin
               zero_start = 1'b1;
            end
         end
         CMD: if (!wr_buf_afull) begin
            cmd_fire  = 1'b1;
            state_nxt = DATA;
         end
         DATA: begin
            beat_acc   = usr_data_valid && usr_data_ready;
            final_beat = beat_acc && (cnt == beats - 9'd1);
            if (final_beat) state_nxt = (rem == LEN_WIDTH'(beats)) ? DONE : CMD;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or negedge resetn) begin
      if (!resetn) begin
         addr           <= '0;
         rem            <= '0;
         beats          <= '0;
         cnt            <= '0;
         usr_data_ready <= 1'b0;
         usr_wr_busy    <= 1'b0;
         usr_wr_done    <= 1'b0;
         wr_req_en      <= 1'b0;
         wr_addr_in     <= '0;
         wr_burst_len   <= '0;
         wr_data_in     <= '0;
         wr_data_valid  <= 1'b0;
         wr_data_last   <= 1'b0;
      end else begin
         wr_req_en     <= cmd_fire;
         wr_data_valid <= beat_acc;
         wr_data_last  <= final_beat;
         usr_wr_done   <= zero_start || (state == DONE);
         if (job_start) begin
            addr        <= {usr_wr_addr[AXI_ADDR_WIDTH-1:BSH], {BSH{1'b0}}};
            rem         <= usr_wr_len;
            usr_wr_busy <= 1'b1;
         end
         if (cmd_fire) begin
            wr_addr_in     <= addr;
            wr_burst_len   <= 8'(beats_calc - CW'(1));
            beats          <= 9'(beats_calc);
            cnt            <= '0;
            usr_data_ready <= 1'b1;
         end
         if (beat_acc) begin
            wr_data_in <= usr_data;
            cnt        <= cnt + 9'd1;
         end
         // ready drops on the same edge that takes the final beat
         if (final_beat) begin
            usr_data_ready <= 1'b0;
            addr           <= addr + (AXI_ADDR_WIDTH'(beats) << BSH);
            rem            <= rem - LEN_WIDTH'(beats);
         end
         if (state == DONE) usr_wr_busy <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Bench for wr_burst_ctrl: a job-level model predicts commands and beats; a monitor compares every cycle.
module tb_wr_burst_ctrl;
   typedef struct packed {logic [31:0] a; logic [7:0] l;} cmd_t;
   typedef struct packed {logic [127:0] d; logic last;} beat_t;

   logic         wr_clk = 1'b0, resetn = 1'b0;
   logic         usr_wr_start = 1'b0, usr_data_valid = 1'b0, wr_buf_afull = 1'b0;
   logic [31:0]  usr_wr_addr = '0;
   logic [15:0]  usr_wr_len = '0;
   logic [127:0] usr_data = '0;
   logic         usr_data_ready, usr_wr_busy, usr_wr_done, wr_req_en, wr_data_valid, wr_data_last;
   logic [31:0]  wr_addr_in;
   logic [7:0]   wr_burst_len;
   logic [127:0] wr_data_in;

   wr_burst_ctrl #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(128), .LEN_WIDTH(16), .MAX_BURST(256)) dut (
      .wr_clk(wr_clk), .resetn(resetn), .usr_wr_start(usr_wr_start), .usr_wr_addr(usr_wr_addr),
      .usr_wr_len(usr_wr_len), .usr_data(usr_data), .usr_data_valid(usr_data_valid),
      .usr_data_ready(usr_data_ready), .usr_wr_busy(usr_wr_busy), .usr_wr_done(usr_wr_done),
      .wr_buf_afull(wr_buf_afull), .wr_req_en(wr_req_en), .wr_addr_in(wr_addr_in),
      .wr_burst_len(wr_burst_len), .wr_data_in(wr_data_in), .wr_data_valid(wr_data_valid),
      .wr_data_last(wr_data_last));

   always #5 wr_clk = ~wr_clk;

   int checks = 0, errors = 0, done_cnt = 0, avail = 0;
   bit mon_en = 1'b0;
   cmd_t  exp_cmd[$], cmd_log[$];
   beat_t exp_beat[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] pat(input int jid, input int i);
      return {32'hA5A5_0000 | 32'(jid), 32'(i), ~32'(i), 32'(i * 3 + jid)};
   endfunction

   // Job-level model: whole bursts from the splitting rules, plus the beat stream they imply.
   task automatic model_job(input logic [31:0] addr, input int len, input int jid);
      logic [31:0] a = addr & 32'hFFFF_FFF0;
      int rem = len, b, k = 0;
      while (rem > 0) begin
         b = (rem > 256) ? 256 : rem;
`ifdef WR_BURST_4K_SPLIT_EN
         if ((4096 - int'(a[11:0])) / 16 < b) b = (4096 - int'(a[11:0])) / 16;
`endif
         exp_cmd.push_back('{a, 8'(b - 1)});
         for (int j = 0; j < b; j++) begin
            exp_beat.push_back('{pat(jid, k), (j == b - 1)});
            k++;
         end
         a += 32'(b * 16);
         rem -= b;
      end
   endtask

   always @(negedge wr_clk) begin
      if (resetn && usr_wr_done) done_cnt++;
      if (resetn && mon_en) begin
         // data first: a coincident command belongs to the next burst
         if (wr_data_valid) begin
            if (exp_beat.size() == 0 || avail == 0) chk("beat_unexpected", 1, 0);
            else begin
               chk("beat_data", wr_data_in, exp_beat[0].d);
               chk("beat_last", wr_data_last, exp_beat[0].last);
               void'(exp_beat.pop_front());
               avail--;
            end
         end
         if (wr_req_en) begin
            cmd_log.push_back('{wr_addr_in, wr_burst_len});
            if (exp_cmd.size() == 0) chk("cmd_extra", 1, 0);
            else begin
               chk("cmd_addr", wr_addr_in, exp_cmd[0].a);
               chk("cmd_len", wr_burst_len, exp_cmd[0].l);
               void'(exp_cmd.pop_front());
               avail += int'(wr_burst_len) + 1;
            end
         end
      end
   end

   // Assumes entry at posedge+1; returns at posedge+1.
   task automatic run_job(input logic [31:0] addr, input int len, input int jid, input bit gaps,
                          input bit poke, input bit afull, input int abort_after);
      int d0 = done_cnt, t;
      bit acc;
      model_job(addr, len, jid);
      wr_buf_afull = afull;
      usr_wr_start = 1'b1; usr_wr_addr = addr; usr_wr_len = 16'(len);
      @(posedge wr_clk); #1 usr_wr_start = 1'b0;
      @(negedge wr_clk); chk("busy_after_start", usr_wr_busy, 1);
      if (afull) begin
         for (int c = 0; c < 10; c++) begin
            @(negedge wr_clk); chk("afull_no_cmd", wr_req_en, 0);
         end
      end
      @(posedge wr_clk); #1 wr_buf_afull = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (i == abort_after) return;
         if (gaps) begin
            usr_data_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge wr_clk); #1; end
         end
         if (poke && i == 2) begin
            usr_wr_start = 1'b1; usr_wr_addr = 32'h5550; usr_wr_len = 16'd7;
         end
         usr_data = pat(jid, i); usr_data_valid = 1'b1;
         acc = 1'b0; t = 0;
         while (!acc && t < 300) begin
            @(negedge wr_clk); if (usr_data_ready) acc = 1'b1;
            @(posedge wr_clk); #1 t++;
         end
         usr_wr_start = 1'b0;
         if (!acc) begin chk("beat_accept_timeout", 0, 1); break; end
      end
      usr_data_valid = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 2000) begin @(negedge wr_clk); t++; end
      repeat (3) @(negedge wr_clk);
      chk("done_once", done_cnt, d0 + 1);
      chk("busy_cleared", usr_wr_busy, 0);
      chk("cmd_q_empty", exp_cmd.size(), 0);
      chk("beat_q_empty", exp_beat.size(), 0);
      @(posedge wr_clk); #1;
   endtask

   initial begin
      int d0;
      repeat (3) @(negedge wr_clk);
      chk("rst_ctrl", {wr_req_en, wr_data_valid, wr_data_last, usr_data_ready, usr_wr_busy, usr_wr_done}, 0);
      chk("rst_data", {wr_addr_in, wr_burst_len, wr_data_in}, 0);
      @(posedge wr_clk); #1 resetn = 1'b1; mon_en = 1'b1;
      @(posedge wr_clk); #1;

      // T1: single short burst
      cmd_log.delete();
      run_job(32'h0, 4, 1, 0, 0, 0, -1);
      chk("t1_ncmd", cmd_log.size(), 1);
      if (cmd_log.size() >= 1) chk("t1_cmd", cmd_log[0], {32'h0, 8'd3});

      // T2: MAX_BURST splitting
      cmd_log.delete();
      run_job(32'h0, 600, 2, 0, 0, 0, -1);
      chk("t2_ncmd", cmd_log.size(), 3);
      if (cmd_log.size() >= 3) begin
         chk("t2_cmd0", cmd_log[0], {32'h0000, 8'd255});
         chk("t2_cmd1", cmd_log[1], {32'h1000, 8'd255});
         chk("t2_cmd2", cmd_log[2], {32'h2000, 8'd87});
      end

      // T3: 4KB boundary
      cmd_log.delete();
      run_job(32'h0FC0, 8, 3, 1, 0, 0, -1);
`ifdef WR_BURST_4K_SPLIT_EN
      chk("t3_ncmd", cmd_log.size(), 2);
      if (cmd_log.size() >= 2) begin
         chk("t3_cmd0", cmd_log[0], {32'h0FC0, 8'd3});
         chk("t3_cmd1", cmd_log[1], {32'h1000, 8'd3});
      end
`else
      chk("t3_ncmd", cmd_log.size(), 1);
      if (cmd_log.size() >= 1) chk("t3_cmd0", cmd_log[0], {32'h0FC0, 8'd7});
`endif

      // T4: zero-length job, then start while busy with an unaligned address
      cmd_log.delete();
      usr_wr_start = 1'b1; usr_wr_addr = 32'h40; usr_wr_len = 16'd0;
      @(posedge wr_clk); #1 usr_wr_start = 1'b0;
      @(negedge wr_clk);
      chk("len0_done", usr_wr_done, 1);
      chk("len0_busy", usr_wr_busy, 0);
      @(negedge wr_clk); chk("len0_done_pulse", usr_wr_done, 0);
      @(posedge wr_clk); #1;
      chk("len0_no_cmd", cmd_log.size(), 0);
      run_job(32'h123, 10, 4, 1, 1, 0, -1);
      chk("t4_ncmd", cmd_log.size(), 1);
      if (cmd_log.size() >= 1) chk("t4_cmd", cmd_log[0], {32'h120, 8'd9});

      // T5: afull hold-off, gaps with address wrap, reset mid-DATA
      run_job(32'h300, 5, 5, 0, 0, 1, -1);
      run_job(32'hFFFF_FF80, 40, 6, 1, 0, 0, -1);
      d0 = done_cnt;
      run_job(32'h2000, 20, 7, 1, 0, 0, 5);
      mon_en = 1'b0; resetn = 1'b0;
      @(negedge wr_clk);
      chk("abort_ctrl", {wr_req_en, wr_data_valid, wr_data_last, usr_data_ready, usr_wr_busy, usr_wr_done}, 0);
      chk("abort_data", {wr_addr_in, wr_burst_len, wr_data_in}, 0);
      exp_cmd.delete(); exp_beat.delete();
      @(posedge wr_clk); #1 resetn = 1'b1;
      @(posedge wr_clk); #1 mon_en = 1'b1;
      chk("abort_no_done", done_cnt, d0);
      cmd_log.delete();
      run_job(32'h40, 3, 8, 0, 0, 0, -1);
      chk("recover_cmd", (cmd_log.size() == 1) ? cmd_log[0] : 40'h0, {32'h40, 8'd2});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   always @(posedge wr_clk) avail_reset: if (!mon_en) avail = 0;
endmodule
